// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry skid pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam bit BUBBLE_ZERO_DEF = 1'b1;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for both sides of the skid stage.
interface pipe_skid_reg_if #(
    parameter int DATA_W = 160
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // master: the environment around the stage (upstream producer + downstream consumer)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] ONE_VAL = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + ONE_VAL;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry (main + skid) pipeline register with registered in_ready and flush.
// Optional perf counters (stall_cnt, flush_cnt) when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 160,
    parameter bit BUBBLE_ZERO = BUBBLE_ZERO_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_skid_reg_if.slave   bus,
    output logic [1:0]       occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    pipe_state_e       state_reg;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] skid_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [1:0]        occ_reg;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = bus.in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & bus.out_ready;

    // Handshake outputs are registered alongside the state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            occ_reg       <= OCC_EMPTY;
        end else if (flush) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            occ_reg       <= OCC_EMPTY;
        end else begin
            in_ready_reg <= 1'b1;
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_reg      <= bus.in_data;
                        state_reg     <= ONE;
                        out_valid_reg <= 1'b1;
                        occ_reg       <= OCC_ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_reg <= bus.in_data;
                    end else if (in_fire) begin
                        skid_reg     <= bus.in_data;
                        state_reg    <= FULL;
                        in_ready_reg <= 1'b0;
                        occ_reg      <= OCC_FULL;
                    end else if (out_fire) begin
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                        occ_reg       <= OCC_EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_reg  <= skid_reg;
                        state_reg <= ONE;
                        occ_reg   <= OCC_ONE;
                    end else begin
                        in_ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    out_valid_reg <= 1'b0;
                    occ_reg       <= OCC_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = (BUBBLE_ZERO && !out_valid_reg) ? '0 : main_reg;
    assign occupancy     = occ_reg;

`ifdef PIPE_SKID_PERF_EN
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid_reg & ~bus.out_ready),
        .clear (1'b0),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .clear (1'b0),
        .count (flush_cnt)
    );
`else
    // Counter width only matters when the perf counters are built.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (perf checks when PIPE_SKID_PERF_EN).
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int DATA_W = 160;
`ifdef PIPE_SKID_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    pipe_skid_reg_if #(.DATA_W(DATA_W)) bus ();

    pipe_skid_reg #(
        .DATA_W      (DATA_W),
        .BUBBLE_ZERO (1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-14s got=%0h", tag, got);
        end else begin
            $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_valid", {159'd0, bus.out_valid}, '0);
        check("rst_occ", {158'd0, occupancy}, '0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_rdy", {159'd0, bus.in_ready}, 1);

        // Streaming 1,2,3 with out_ready high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.in_data = DATA_W'(i);
            step();
            check("stream_data", bus.out_data, DATA_W'(i));
            check("stream_occ", {158'd0, occupancy}, 1);
        end
        bus.in_valid = 1'b0;
        step();
        check("stream_drain", {159'd0, bus.out_valid}, 0);
        check("bubble_zero", bus.out_data, '0);

        // Backpressure: A,B fill both entries, C held upstream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DATA_W'(32'hA);
        step();
        bus.in_data = DATA_W'(32'hB);
        step();
        check("bp_occ_full", {158'd0, occupancy}, 2);
        check("bp_rdy_low", {159'd0, bus.in_ready}, 0);
        bus.in_data = DATA_W'(32'hC);
        step();
        check("bp_hold_A", bus.out_data, DATA_W'(32'hA));
        check("bp_still_full", {158'd0, occupancy}, 2);
        bus.out_ready = 1'b1;
        step();
        check("bp_out_B", bus.out_data, DATA_W'(32'hB));
        check("bp_rdy_back", {159'd0, bus.in_ready}, 1);
        step();
        check("bp_out_C", bus.out_data, DATA_W'(32'hC));
        bus.in_valid = 1'b0;
        step();
        check("bp_empty", {158'd0, occupancy}, 0);

        // Flush while FULL with a new payload offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DATA_W'(32'hA);
        step();
        bus.in_data = DATA_W'(32'hB);
        step();
        check("fl_pre_full", {158'd0, occupancy}, 2);
        flush       = 1'b1;
        bus.in_data = DATA_W'(32'hC);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_occ", {158'd0, occupancy}, 0);
        check("fl_valid", {159'd0, bus.out_valid}, 0);
        check("fl_data", bus.out_data, '0);
        bus.out_ready = 1'b1;
        step();
        step();
        check("fl_no_C", {159'd0, bus.out_valid}, 0);

        // Asynchronous reset in the middle of FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DATA_W'(32'hD);
        step();
        bus.in_data = DATA_W'(32'hE);
        step();
        bus.in_valid = 1'b0;
        check("ar_pre_full", {158'd0, occupancy}, 2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", {159'd0, bus.out_valid}, 0);
        check("ar_data", bus.out_data, '0);
        check("ar_occ", {158'd0, occupancy}, 0);
        step();
        rst = 1'b0;
        step();
        check("ar_rdy", {159'd0, bus.in_ready}, 1);

`ifdef PIPE_SKID_PERF_EN
        check("pf_stall0", {{(DATA_W-CNT_W){1'b0}}, stall_cnt}, '0);
        check("pf_flush0", {{(DATA_W-CNT_W){1'b0}}, flush_cnt}, '0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DATA_W'(32'h5);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("pf_stall_sat", {{(DATA_W-CNT_W){1'b0}}, stall_cnt}, DATA_W'(15));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            step();
        end
        check("pf_flush3", {{(DATA_W-CNT_W){1'b0}}, flush_cnt}, DATA_W'(3));
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160, meaning payload width in bits (bundled decode/control fields).
REQ-002 SHALL have parameter BUBBLE_ZERO, default 1, meaning force out_data to all-zero while out_valid=0.
REQ-003 SHALL have parameter CNT_W, default 16, meaning perf counter width.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 SHALL have port in_ready  output  1  stage can accept, registered.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  output  1  downstream payload valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_data  output  DATA_W  payload from main entry.
REQ-013 SHALL have port occupancy  output  2  entries held (0..2).
REQ-014 SHALL have ports stall_cnt and flush_cnt, each output CNT_W, present only under REQ-029.

Function
REQ-015 SHALL hold two entries, main and skid; out_data/out_valid come from main only.
REQ-016 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 SHALL implement states EMPTY (none), ONE (main), FULL (main+skid); occupancy = 0/1/2 respectively.
REQ-018 EMPTY: in_fire -> ONE, main<=in_data; else stay.
REQ-019 ONE: in_fire&out_fire -> ONE, main<=in_data; in_fire only -> FULL, skid<=in_data; out_fire only -> EMPTY; neither -> stay.
REQ-020 FULL: in_ready=0; out_fire -> ONE, main<=skid; else stay, both entries unchanged.
REQ-021 SHALL give in->out latency of 1 cycle, sustained throughput 1 transfer/cycle when out_ready=1.
REQ-022 SHALL drive in_ready=1 in EMPTY and ONE, 0 in FULL, from registered state only (no combinational in_ready path from out_ready).
REQ-023 flush SHALL have priority over every transition: next state EMPTY, payload accepted in the flush cycle discarded; out_fire in the flush cycle still counts downstream.
REQ-024 With BUBBLE_ZERO=1, out_data SHALL be all-zero whenever out_valid=0; with 0, out_data SHALL hold last main contents.
REQ-025 SHALL never reorder, duplicate or drop payloads except via flush.

Reset
REQ-026 rst SHALL asynchronously force state EMPTY, main and skid data to 0, out_valid=0, out_data=0, occupancy=0.
REQ-027 in_ready SHALL be 1 from the first rising edge after rst deasserts; rst mid-transfer discards both entries.
REQ-028 stall_cnt and flush_cnt SHALL reset to 0.

Configuration
REQ-029 With PIPE_SKID_PERF_EN defined, stall_cnt SHALL increment each cycle out_valid&~out_ready and flush_cnt each cycle flush=1, both saturating at all-ones; without it, those ports and counters SHALL not exist, and the remaining behaviour is identical.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enum (EMPTY/ONE/FULL), occupancy encodings and the bubble constant.
REQ-031 SHALL instantiate sub-module pipe_sat_cnt (saturating CNT_W counter with inc/clear) twice under PIPE_SKID_PERF_EN.

Verification
REQ-032 Reset: rst=1 mid-FULL -> out_valid=0, out_data=0, occupancy=0 immediately; in_ready=1 after release.
REQ-033 Streaming: in_data 0x1,0x2,0x3 on consecutive cycles, out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later, no gaps.
REQ-034 Backpressure: out_ready=0 while sending 0xA,0xB -> occupancy 2, in_ready=0, 0xC held upstream; out_ready=1 -> 0xA,0xB,0xC in order.
REQ-035 Flush: FULL with 0xA,0xB, flush=1 with in_valid=1 in_data=0xC -> next cycle EMPTY, out_valid=0, out_data=0, 0xC never emitted.
REQ-036 Perf (PIPE_SKID_PERF_EN, CNT_W=4): 20 stall cycles -> stall_cnt=15; 3 flush pulses -> flush_cnt=3.
